// File: rtl/cordic_pkg.sv
// Shared types and constants for the folded CORDIC engine. The arctangent table
// is stored at 32-bit resolution (2^32 = one full turn) and rescaled at elaboration.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_ITER = 32;
  localparam int ITER_W   = $clog2(MAX_ITER);

  localparam logic ROT = 1'b0;
  localparam logic VEC = 1'b1;

  // round(atan(2^-i)/pi * 2^(angle_width-1)), valid for angle_width <= 32
  function automatic logic [31:0] atan_lut(input int i, input int angle_width);
    logic [32:0] v;
    int          s;
    case (i)
      0:  v = 33'd536870912;
      1:  v = 33'd316933406;
      2:  v = 33'd167458907;
      3:  v = 33'd85004756;
      4:  v = 33'd42667331;
      5:  v = 33'd21354465;
      6:  v = 33'd10679838;
      7:  v = 33'd5340245;
      8:  v = 33'd2670163;
      9:  v = 33'd1335087;
      10: v = 33'd667544;
      11: v = 33'd333772;
      12: v = 33'd166886;
      13: v = 33'd83443;
      14: v = 33'd41722;
      15: v = 33'd20861;
      16: v = 33'd10430;
      17: v = 33'd5215;
      18: v = 33'd2608;
      19: v = 33'd1304;
      20: v = 33'd652;
      21: v = 33'd326;
      22: v = 33'd163;
      23: v = 33'd81;
      24: v = 33'd41;
      25: v = 33'd20;
      26: v = 33'd10;
      27: v = 33'd5;
      28: v = 33'd3;
      29: v = 33'd1;
      30: v = 33'd1;
      default: v = 33'd0;
    endcase
    s = 32 - angle_width;
    if (s > 0) v = (v + (33'd1 << (s - 1))) >> s;
    return v[31:0];
  endfunction

endpackage

// File: rtl/cordic_micro_rot_var.sv
// One CORDIC micro-rotation with a runtime shift amount; purely combinational.
module cordic_micro_rot_var
  import cordic_pkg::*;
#(
  parameter int XY_W        = 18,
  parameter int ANGLE_WIDTH = 16
) (
  input  logic [XY_W-1:0]        i_x,
  input  logic [XY_W-1:0]        i_y,
  input  logic [ANGLE_WIDTH-1:0] i_z,
  input  logic [ITER_W-1:0]      i_shift,
  input  logic [ANGLE_WIDTH-1:0] i_atan,
  input  logic                   i_mode,
  output logic [XY_W-1:0]        o_x,
  output logic [XY_W-1:0]        o_y,
  output logic [ANGLE_WIDTH-1:0] o_z,
  output logic                   o_d
);

  logic signed [XY_W-1:0] w_x_sh;
  logic signed [XY_W-1:0] w_y_sh;

  assign w_x_sh = $signed(i_x) >>> i_shift;
  assign w_y_sh = $signed(i_y) >>> i_shift;

  // Rotation steers z toward zero, vectoring steers y toward zero.
  assign o_d = (i_mode == VEC) ? i_y[XY_W-1] : ~i_z[ANGLE_WIDTH-1];

  assign o_x = o_d ? (i_x - w_y_sh) : (i_x + w_y_sh);
  assign o_y = o_d ? (i_y + w_x_sh) : (i_y - w_x_sh);
  assign o_z = o_d ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_iter_engine.sv
// Folded CORDIC: one shared micro-rotation reused NUM_ITER times per operand,
// with valid/ready on both sides and the direction sequence exported.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = 16,
  parameter int ANGLE_WIDTH  = 16,
  parameter int NUM_ITER     = 14,
  parameter int GUARD        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [CORDIC_WIDTH-1:0]       x_in,
  input  logic [CORDIC_WIDTH-1:0]       y_in,
  input  logic [ANGLE_WIDTH-1:0]        z_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CORDIC_WIDTH+GUARD-1:0] x_out,
  output logic [CORDIC_WIDTH+GUARD-1:0] y_out,
  output logic [ANGLE_WIDTH-1:0]        z_out,
  output logic [NUM_ITER-1:0]           dir_out
);

  localparam int XY_W = CORDIC_WIDTH + GUARD;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]             r_state;
  logic [ITER_W-1:0]      r_iter;
  logic                   r_mode;
  logic [XY_W-1:0]        r_x;
  logic [XY_W-1:0]        r_y;
  logic [ANGLE_WIDTH-1:0] r_z;
  logic [NUM_ITER-1:0]    r_dir;

  logic [ANGLE_WIDTH-1:0] w_atan_tbl [NUM_ITER];
  logic [ANGLE_WIDTH-1:0] w_atan;
  logic [XY_W-1:0]        w_x_nxt;
  logic [XY_W-1:0]        w_y_nxt;
  logic [ANGLE_WIDTH-1:0] w_z_nxt;
  logic                   w_d;

  for (genvar g = 0; g < NUM_ITER; g++) begin : g_atan
    localparam logic [31:0] ATAN_FULL = atan_lut(g, ANGLE_WIDTH);
    assign w_atan_tbl[g] = ATAN_FULL[ANGLE_WIDTH-1:0];
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_atan = '0;
    for (int j = 0; j < NUM_ITER; j++)
      if (r_iter == ITER_W'(j)) w_atan = w_atan_tbl[j];
  end

  cordic_micro_rot_var #(
    .XY_W        (XY_W),
    .ANGLE_WIDTH (ANGLE_WIDTH)
  ) u_micro_rot (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (w_atan),
    .i_mode  (r_mode),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt),
    .o_d     (w_d)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_mode  <= ROT;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_dir   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x     <= XY_W'($signed(x_in));
            r_y     <= XY_W'($signed(y_in));
            r_z     <= z_in;
            r_mode  <= mode;
            r_iter  <= '0;
            r_dir   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          for (int j = 0; j < NUM_ITER; j++)
            if (r_iter == ITER_W'(j)) r_dir[j] <= w_d;
          if (r_iter == ITER_W'(NUM_ITER - 1)) r_state <= S_DONE;
          else                                 r_iter  <= r_iter + ITER_W'(1);
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign z_out     = r_z;
  assign dir_out   = r_dir;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine with hand-derived expected results.
module tb_cordic_iter_engine;

  localparam int CW = 16;
  localparam int AW = 16;
  localparam int NI = 14;
  localparam int G  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            mode;
  logic [CW-1:0]   x_in;
  logic [CW-1:0]   y_in;
  logic [AW-1:0]   z_in;
  logic            out_valid;
  logic            out_ready;
  logic [CW+G-1:0] x_out;
  logic [CW+G-1:0] y_out;
  logic [AW-1:0]   z_out;
  logic [NI-1:0]   dir_out;

  int total = 0;
  int bad   = 0;

  cordic_iter_engine #(
    .CORDIC_WIDTH (CW),
    .ANGLE_WIDTH  (AW),
    .NUM_ITER     (NI),
    .GUARD        (G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .dir_out   (dir_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [31:0] obs,
                            input int expv, input int tol);
    total++;
    assert ((obs >= expv - tol && obs <= expv + tol) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge after the accept edge.
  task automatic send(input logic m, input int x, input int y, input int z);
    mode     = m;
    x_in     = CW'(x);
    y_in     = CW'(y);
    z_in     = AW'(z);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode     = ~m;
    x_in     = 16'h7abc;
    y_in     = 16'h8123;
    z_in     = 16'h4321;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check(tag, lat, NI);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  initial begin
    int last;
    int n_acc;
    int n_out;
    int n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x",   $signed(x_out), 0);
    check("rst_y",   $signed(y_out), 0);
    check("rst_z",   $signed(z_out), 0);
    check("rst_dir", dir_out, 0);
    reset = 1'b0;
    @(negedge clk);

    // Rotation by +45 degrees, traced iteration by iteration
    send(1'b0, 10000, 0, 8192);
    check("run_in_ready",  in_ready, 0);
    check("run_out_valid", out_valid, 0);
    wait_done("rot45_latency");
    check("rot45_x",   $signed(x_out), 11645);
    check("rot45_y",   $signed(y_out), 11645);
    check("rot45_z",   $signed(z_out), 1);
    check("rot45_dir", dir_out, 'h2F83);

    // Back-pressure with a competing input beat that must not be taken
    mode = 1'b1; x_in = 16'd1234; y_in = 16'd4321; z_in = 16'd100; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready, 0);
      check("bp_x",   $signed(x_out), 11645);
      check("bp_dir", dir_out, 'h2F83);
    end
    in_valid = 1'b0;
    handshake("bp_release");
    check("idle_hold_x", $signed(x_out), 11645);
    check("idle_hold_z", $signed(z_out), 1);

    // Vectoring of (10000, 10000)
    send(1'b1, 10000, 10000, 0);
    wait_done("vec_latency");
    check_near("vec_x", $signed(x_out), 23289, 4);
    check_near("vec_y", $signed(y_out), 0, 3);
    check_near("vec_z", $signed(z_out), 8192, 2);
    check("vec_dir0", dir_out[0], 0);
    handshake("vec_release");

    // Rotation by -45 degrees
    send(1'b0, 10000, 0, -8192);
    wait_done("neg45_latency");
    check_near("neg45_x", $signed(x_out), 11645, 4);
    check_near("neg45_y", $signed(y_out), -11645, 4);
    check_near("neg45_z", $signed(z_out), 0, 2);
    check("neg45_dir0", dir_out[0], 0);
    check("neg45_dir",  dir_out, 'h2F82);
    handshake("neg45_release");

    // Back-to-back with in_valid and out_ready held high
    mode = 1'b0; x_in = 16'd10000; y_in = 16'd0; z_in = 16'd8192;
    in_valid = 1'b1; out_ready = 1'b1;
    last = -1; n_acc = 0; n_out = 0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready === 1'b1) begin
        if (last >= 0) check("b2b_spacing", c - last, NI + 2);
        last = c;
        n_acc++;
      end
      if (out_valid === 1'b1) begin
        n_out++;
        check("b2b_x", $signed(x_out), 11645);
      end
      @(negedge clk);
    end
    check("b2b_accepts", n_acc, 4);
    check("b2b_outputs", n_out, 3);
    in_valid = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", in_ready, 1);
    out_ready = 1'b0;

    // Reset landing on iteration 5
    send(1'b0, 10000, 0, 8192);
    repeat (5) @(negedge clk);
    check("mid_x", $signed(x_out), 11259);
    check("mid_y", $signed(y_out), 12003);
    check("mid_out_valid", out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_in_ready",  in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_x",   $signed(x_out), 0);
    check("mrst_y",   $signed(y_out), 0);
    check("mrst_z",   $signed(z_out), 0);
    check("mrst_dir", dir_out, 0);

    send(1'b0, 10000, 0, 8192);
    wait_done("post_rst_latency");
    check("post_rst_x",   $signed(x_out), 11645);
    check("post_rst_y",   $signed(y_out), 11645);
    check("post_rst_dir", dir_out, 'h2F83);
    handshake("post_rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Folded, parametrised CORDIC engine. A single shared micro-rotation datapath is reused for NUM_ITER iterations with a per-iteration variable shift. It supports rotation mode (drive z to 0) and vectoring mode (drive y to 0), uses a valid/ready handshake on both sides, and exports the micro-rotation direction sequence so that vectoring results can steer downstream rotation slaves in the ICA datapath. It replaces one-stage-per-module pipelines where area matters more than throughput.

## Interface
- CORDIC_WIDTH, 16: signed x/y input width.
- ANGLE_WIDTH, 16: signed z width. ±2^(ANGLE_WIDTH-1) represents ±π.
- NUM_ITER, 14: iterations, 1..CORDIC_WIDTH.
- GUARD, 2: MSB guard bits on internal x/y.
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept.
- mode  in  1  0 = rotation, 1 = vectoring. Sampled on accept.
- x_in, y_in  in  CORDIC_WIDTH  signed operands.
- z_in  in  ANGLE_WIDTH  signed angle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- x_out, y_out  out  CORDIC_WIDTH+GUARD  signed results. Gain ≈1.64676 is not compensated.
- z_out  out  ANGLE_WIDTH  residual angle (rotation) or accumulated angle (vectoring).
- dir_out  out  NUM_ITER  bit i = direction of iteration i (1 = anticlockwise).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load x/y sign-extended by GUARD bits, load z, latch mode, clear iter counter and dir register, go to RUN.
- RUN: one iteration per cycle, at iteration index i.
  - Direction d:
    - Rotation mode: d = 1 if z ≥ 0.
    - Vectoring mode: d = 1 if y < 0.
  - d = 1: x ← x − (y>>>i), y ← y + (x>>>i), z ← z − atan_i.
  - d = 0: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + atan_i.
  - Shifts are arithmetic. Truncation only, no rounding. Wrap-around in two's complement. GUARD bits prevent overflow for |x|,|y| < 2^(CORDIC_WIDTH-1).
  - dir_out bit i ← d.
  - When i = NUM_ITER−1, go to DONE.
- DONE:
  - out_valid = 1. Outputs are stable until out_ready.
  - On out_ready: go to IDLE.
- atan_i = round(atan(2^-i)/π · 2^(ANGLE_WIDTH-1)).
- Convergence covers |angle| ≤ ~99.8°. There is no quadrant pre-rotation; out-of-range inputs give unspecified but deterministic results.
- x_out, y_out, z_out and dir_out hold the final registers. They remain stable in IDLE until the next accept.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, x_out/y_out/z_out 0, dir_out 0, iter counter 0.
- Accept at edge k (in_valid & in_ready).
- Iterations occupy edges k+1 .. k+NUM_ITER.
- out_valid is high from after edge k+NUM_ITER.
- Latency from accept to out_valid: NUM_ITER cycles.
- in_ready is 0 in RUN and DONE. No new accept occurs in the cycle of the output handshake.
- Minimum initiation interval: NUM_ITER+2 cycles.
- out_ready held high: DONE lasts exactly one cycle.
- out_ready low: DONE holds indefinitely with all outputs frozen.
- Inputs change during RUN: ignored.
- in_valid during RUN/DONE: not accepted and not queued.
- Reset asserted mid-RUN or in DONE: next cycle is IDLE, all outputs are at reset values, and the partial result is discarded.

## Structure
- Package cordic_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - constant MAX_ITER = 32.
  - function atan_lut(i, ANGLE_WIDTH) evaluated at elaboration.
  - mode encodings ROT = 0, VEC = 1.
- Sub-module cordic_micro_rot_var: combinational single iteration with runtime shift amount.
  - Inputs: x, y, z, shift, atan, mode.
  - Outputs: x', y', z', d.
- Top level holds the FSM, counter and registers.

## Test plan
- Rotation, CORDIC_WIDTH=16, ANGLE_WIDTH=16, NUM_ITER=14: x=10000, y=0, z=8192 (45°) → out_valid exactly 14 cycles after accept; x_out ≈ y_out ≈ 11645 ±4; z_out within ±2 of 0.
- Vectoring: x=10000, y=10000, z=0 → x_out ≈ 23289 ±4, y_out within ±3 of 0, z_out ≈ 8192 ±2, dir_out[0] = 0.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid → outputs frozen and in_ready=0 throughout; raise out_ready → IDLE next cycle, in_ready=1.
- Back-to-back, in_valid always high and out_ready always high → accepts spaced exactly NUM_ITER+2 cycles; in_valid pulses during RUN are not accepted.
- Reset asserted at iteration 5 → next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1; a following accepted beat produces a correct result.
- Negative angle, rotation: x=10000, y=0, z=−8192 → x_out ≈ 11645, y_out ≈ −11645 (±4); dir_out[0] = 0.
